// File: rtl/uart_echo_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// uart_echo_bridge : FIFO-buffered RX->TX byte bridge with heartbeat and flags
// Revision 1.0
// =============================================================================
module uart_echo_bridge #(
   parameter int unsigned       DATA_W     = 8,
   parameter int unsigned       DEPTH      = 16,
   parameter int unsigned       HB_PERIOD  = 50_000_000,
   parameter logic [DATA_W-1:0] HB_BYTE    = 8'h55,
   parameter int unsigned       TX_TIMEOUT = 1_000_000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [1:0]             mode_i,
   input  logic                   rx_valid_i,
   input  logic [DATA_W-1:0]      rx_data_i,
   output logic                   tx_start_o,
   output logic [DATA_W-1:0]      tx_data_o,
   input  logic                   tx_done_i,
   output logic [$clog2(DEPTH):0] fifo_level_o,
   output logic                   overflow_o,
   output logic                   timeout_o,
   input  logic                   clr_flags_i
);

   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned LW  = AW + 1;
   localparam int unsigned HBW = $clog2(HB_PERIOD);
   localparam int unsigned TW  = $clog2(TX_TIMEOUT + 1);

   localparam logic [LW-1:0]  c_full    = LW'(DEPTH);
   localparam logic [HBW-1:0] c_hb_last = HBW'(HB_PERIOD - 1);
   localparam logic [TW-1:0]  c_to_last = TW'(TX_TIMEOUT - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]       level_q, level_d;
   logic                tx_start_q, tx_start_d;
   logic [DATA_W-1:0]   tx_data_q, tx_data_d;
   logic [TW-1:0]       to_cnt_q, to_cnt_d;
   logic [HBW-1:0]      hb_cnt_q, hb_cnt_d;
   logic                hb_pend_q, hb_pend_d;
   logic                overflow_q, overflow_d;
   logic                timeout_q, timeout_d;

   logic w_echo_en, w_hb_en, w_full, w_empty;
   logic w_pop, w_push, w_push_drop, w_hb_wrap, w_hb_take, w_to_hit;

   assign w_echo_en   = mode_i[0];
   assign w_hb_en     = mode_i[1];
   assign w_full      = (level_q == c_full);
   assign w_empty     = (level_q == '0);
   assign w_pop       = (state_q == ST_IDLE) && !w_empty && w_echo_en;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_push      = rx_valid_i && w_echo_en && (!w_full || w_pop);
   assign w_push_drop = rx_valid_i && w_echo_en && w_full && !w_pop;
   assign w_hb_wrap   = w_hb_en && (hb_cnt_q == c_hb_last);
   assign w_hb_take   = (state_q == ST_IDLE) && !w_pop && hb_pend_q;

   always_comb begin
      state_d    = state_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      to_cnt_d   = to_cnt_q;
      w_to_hit   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (w_pop) begin
               tx_data_d  = mem[rd_ptr_q];
               tx_start_d = 1'b1;
               to_cnt_d   = '0;
               state_d    = ST_WAIT;
            end else if (hb_pend_q) begin
               tx_data_d  = HB_BYTE;
               tx_start_d = 1'b1;
               to_cnt_d   = '0;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (tx_done_i) begin
               state_d = ST_IDLE;
            end else if (to_cnt_q == c_to_last) begin
               w_to_hit = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + TW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({w_push, w_pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_comb begin
      hb_cnt_d  = '0;
      hb_pend_d = hb_pend_q;
      if (w_hb_en && !w_hb_wrap) hb_cnt_d = hb_cnt_q + HBW'(1);
      // Wraps while a request is already pending collapse into that request.
      if (!w_hb_en)       hb_pend_d = 1'b0;
      else if (w_hb_wrap) hb_pend_d = 1'b1;
      else if (w_hb_take) hb_pend_d = 1'b0;

      overflow_d = overflow_q;
      timeout_d  = timeout_q;
      if (clr_flags_i) begin
         overflow_d = 1'b0;
         timeout_d  = 1'b0;
      end
      if (w_push_drop) overflow_d = 1'b1;
      if (w_to_hit)    timeout_d  = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (w_push) mem[wr_ptr_q] <= rx_data_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         to_cnt_q   <= '0;
         hb_cnt_q   <= '0;
         hb_pend_q  <= 1'b0;
         overflow_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         to_cnt_q   <= to_cnt_d;
         hb_cnt_q   <= hb_cnt_d;
         hb_pend_q  <= hb_pend_d;
         overflow_q <= overflow_d;
         timeout_q  <= timeout_d;
      end
   end

   assign tx_start_o   = tx_start_q;
   assign tx_data_o    = tx_data_q;
   assign fifo_level_o = level_q;
   assign overflow_o   = overflow_q;
   assign timeout_o    = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// tb_uart_echo_bridge : directed table, corner sequences and random vs. model
// Revision 1.0
// =============================================================================
module tb_uart_echo_bridge;

   localparam int          DEPTH = 16;
   localparam int          HBP   = 100;
   localparam int          TO    = 50;
   localparam logic [7:0]  HB    = 8'h55;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] mode_i = 2'b00;
   logic       rx_valid_i = 1'b0;
   logic [7:0] rx_data_i = 8'h00;
   logic       tx_done_i = 1'b0;
   logic       clr_flags_i = 1'b0;
   logic       tx_start_o;
   logic [7:0] tx_data_o;
   logic [4:0] fifo_level_o;
   logic       overflow_o;
   logic       timeout_o;

   uart_echo_bridge #(
      .DATA_W(8), .DEPTH(DEPTH), .HB_PERIOD(HBP), .HB_BYTE(HB), .TX_TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mode_i(mode_i),
      .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
      .tx_start_o(tx_start_o), .tx_data_o(tx_data_o), .tx_done_i(tx_done_i),
      .fifo_level_o(fifo_level_o), .overflow_o(overflow_o), .timeout_o(timeout_o),
      .clr_flags_i(clr_flags_i)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   bit mon_en  = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      else             n_pass++;
   endtask

   // Reference model: byte queue plus plain counters.
   logic [7:0] mq[$];
   bit         m_busy, m_pend, m_start, m_ovf, m_to;
   int         m_wait, m_hb;
   logic [7:0] m_data;

   task automatic model_reset();
      mq.delete();
      m_busy = 0; m_pend = 0; m_start = 0; m_ovf = 0; m_to = 0;
      m_wait = 0; m_hb = 0; m_data = 8'h00;
   endtask

   task automatic model_step();
      bit echo, hb_en, popped, consumed, wrap;
      int lvl;
      echo = mode_i[0]; hb_en = mode_i[1];
      lvl = mq.size();
      popped = 0; consumed = 0; wrap = 0; m_start = 0;
      if (clr_flags_i) begin m_ovf = 0; m_to = 0; end
      if (!m_busy) begin
         if (echo && lvl > 0) begin
            m_data = mq.pop_front(); popped = 1; m_start = 1; m_busy = 1; m_wait = 0;
         end else if (m_pend) begin
            m_data = HB; consumed = 1; m_start = 1; m_busy = 1; m_wait = 0;
         end
      end else begin
         if (tx_done_i)          m_busy = 0;
         else if (m_wait == TO-1) begin m_busy = 0; m_to = 1; end
         else                    m_wait++;
      end
      if (rx_valid_i && echo) begin
         if (lvl < DEPTH || popped) mq.push_back(rx_data_i);
         else                       m_ovf = 1;
      end
      if (hb_en) begin
         if (m_hb == HBP-1) begin m_hb = 0; wrap = 1; end
         else m_hb++;
      end else m_hb = 0;
      if (!hb_en)        m_pend = 0;
      else if (wrap)     m_pend = 1;
      else if (consumed) m_pend = 0;
   endtask

   function automatic logic [15:0] pack(logic s, logic [7:0] d, logic [4:0] l, logic o, logic t);
      return {s, d, l, o, t};
   endfunction

   always @(posedge clk) if (rst_n) model_step();

   always @(negedge clk)
      if (rst_n && mon_en)
         chk("model", 32'(pack(tx_start_o, tx_data_o, fifo_level_o, overflow_o, timeout_o)),
                      32'(pack(m_start, m_data, 5'(mq.size()), m_ovf, m_to)));

   task automatic step(input logic [1:0] m, input logic v, input logic [7:0] d,
                       input logic dn, input logic c);
      mode_i = m; rx_valid_i = v; rx_data_i = d; tx_done_i = dn; clr_flags_i = c;
      @(negedge clk);
      rx_valid_i = 1'b0; tx_done_i = 1'b0; clr_flags_i = 1'b0;
   endtask

   task automatic wait_start(input string nm, input logic [7:0] exp_d, input int lim);
      int i = 0;
      while (!tx_start_o && i < lim) begin
         step(mode_i, 1'b0, 8'h00, 1'b0, 1'b0);
         i++;
      end
      chk({nm, "_start"}, 32'(tx_start_o), 32'd1);
      chk({nm, "_data"},  32'(tx_data_o),  32'(exp_d));
   endtask

   typedef struct packed {
      logic [1:0] mode; logic v; logic [7:0] d; logic dn; logic c;
      logic e_s; logic [7:0] e_d; logic [4:0] e_l; logic e_o; logic e_t;
   } vec_t;

   function automatic vec_t mkv(logic [1:0] m, logic v, logic [7:0] d, logic dn, logic c,
                                logic es, logic [7:0] ed, logic [4:0] el);
      return '{mode: m, v: v, d: d, dn: dn, c: c, e_s: es, e_d: ed, e_l: el, e_o: 1'b0, e_t: 1'b0};
   endfunction

   vec_t tbl [20];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         starts[$];
      int         dcnt, nst;
      logic [1:0] rm;
      int         dp;

      tbl[0] = mkv(2'b01, 1, 8'hA5, 0, 0, 0, 8'h00, 5'd1);
      tbl[1] = mkv(2'b01, 0, 8'h00, 0, 0, 1, 8'hA5, 5'd0);
      for (int i = 2; i < 12; i++) tbl[i] = mkv(2'b01, 0, 8'h00, 0, 0, 0, 8'hA5, 5'd0);
      tbl[12] = mkv(2'b01, 0, 8'h00, 1, 0, 0, 8'hA5, 5'd0);
      tbl[13] = mkv(2'b01, 1, 8'h3C, 0, 0, 0, 8'hA5, 5'd1);
      tbl[14] = mkv(2'b01, 0, 8'h00, 0, 0, 1, 8'h3C, 5'd0);
      tbl[15] = mkv(2'b01, 0, 8'h00, 1, 0, 0, 8'h3C, 5'd0);
      tbl[16] = mkv(2'b01, 0, 8'h00, 0, 1, 0, 8'h3C, 5'd0);
      tbl[17] = mkv(2'b01, 0, 8'h00, 1, 0, 0, 8'h3C, 5'd0);
      tbl[18] = mkv(2'b00, 1, 8'h77, 0, 0, 0, 8'h3C, 5'd0);
      tbl[19] = mkv(2'b01, 0, 8'h00, 0, 0, 0, 8'h3C, 5'd0);

      model_reset();
      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'(pack(tx_start_o, tx_data_o, fifo_level_o, overflow_o, timeout_o)), 32'd0);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Single echo with latency N+2, then back to IDLE.
      for (int i = 0; i < 20; i++) begin
         step(tbl[i].mode, tbl[i].v, tbl[i].d, tbl[i].dn, tbl[i].c);
         chk($sformatf("vec%0d", i),
             32'(pack(tx_start_o, tx_data_o, fifo_level_o, overflow_o, timeout_o)),
             32'(pack(tbl[i].e_s, tbl[i].e_d, tbl[i].e_l, tbl[i].e_o, tbl[i].e_t)));
      end

      // Fill to full while the transmitter stalls, then overflow.
      for (int i = 0; i < 17; i++) step(2'b01, 1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_level", 32'(fifo_level_o), 32'd16);
      chk("fill_no_ovf", 32'(overflow_o), 32'd0);
      chk("fill_head", 32'(tx_data_o), 32'h00);
      step(2'b01, 1'b1, 8'h11, 1'b0, 1'b1);
      chk("ovf_set_wins", 32'(overflow_o), 32'd1);
      chk("ovf_level", 32'(fifo_level_o), 32'd16);
      step(2'b01, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("ovf_clear", 32'(overflow_o), 32'd0);
      for (int k = 1; k <= 16; k++) begin
         step(2'b01, 1'b0, 8'h00, 1'b1, 1'b0);
         wait_start($sformatf("drain%0d", k), 8'(k), 4);
      end
      step(2'b01, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_level", 32'(fifo_level_o), 32'd0);

      // Heartbeat only: rx ignored, one 0x55 every HBP cycles.
      dcnt = 0;
      for (int c = 0; c < 350; c++) begin
         logic dn;
         dn = (dcnt == 1);
         if (dcnt > 0) dcnt--;
         step(2'b10, (c % 7) == 0, 8'(c), dn, 1'b0);
         if (tx_start_o) begin
            starts.push_back(c);
            chk("hb_data", 32'(tx_data_o), 32'(HB));
            dcnt = 3;
         end
      end
      chk("hb_count", 32'(starts.size()), 32'd3);
      if (starts.size() == 3) begin
         chk("hb_first", 32'(starts[0]), 32'd100);
         chk("hb_gap1", 32'(starts[1] - starts[0]), 32'd100);
         chk("hb_gap2", 32'(starts[2] - starts[1]), 32'd100);
      end
      chk("hb_no_fwd", 32'(fifo_level_o), 32'd0);
      repeat (3) step(2'b01, 1'b0, 8'h00, 1'b0, 1'b0);

      // Echo data outranks a pending heartbeat.
      for (int c = 0; c < 80; c++) step(2'b11, 1'b0, 8'h00, 1'b0, 1'b0);
      step(2'b11, 1'b1, 8'hC0, 1'b0, 1'b0);
      step(2'b11, 1'b1, 8'hC1, 1'b0, 1'b0);
      step(2'b11, 1'b1, 8'hC2, 1'b0, 1'b0);
      step(2'b11, 1'b1, 8'hC3, 1'b0, 1'b0);
      repeat (25) step(2'b11, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("prio_level", 32'(fifo_level_o), 32'd3);
      chk("prio_cur", 32'(tx_data_o), 32'hC0);
      step(2'b11, 1'b0, 8'h00, 1'b1, 1'b0); wait_start("prio_c1", 8'hC1, 4);
      step(2'b11, 1'b0, 8'h00, 1'b1, 1'b0); wait_start("prio_c2", 8'hC2, 4);
      step(2'b11, 1'b0, 8'h00, 1'b1, 1'b0); wait_start("prio_c3", 8'hC3, 4);
      step(2'b11, 1'b0, 8'h00, 1'b1, 1'b0); wait_start("prio_hb", HB, 4);
      step(2'b11, 1'b0, 8'h00, 1'b1, 1'b0);
      nst = 0;
      for (int c = 0; c < 40; c++) begin
         step(2'b11, 1'b0, 8'h00, 1'b0, 1'b0);
         nst += int'(tx_start_o);
      end
      chk("hb_once", 32'(nst), 32'd0);
      repeat (2) step(2'b01, 1'b0, 8'h00, 1'b0, 1'b0);

      // Timeout: byte lost, next byte starts, flag clears.
      step(2'b01, 1'b1, 8'hAA, 1'b0, 1'b0);
      step(2'b01, 1'b1, 8'hBB, 1'b0, 1'b0);
      chk("to_first", 32'(pack(tx_start_o, tx_data_o, fifo_level_o, 1'b0, timeout_o)),
                      32'(pack(1'b1, 8'hAA, 5'd1, 1'b0, 1'b0)));
      repeat (49) step(2'b01, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("to_not_yet", 32'(timeout_o), 32'd0);
      step(2'b01, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("to_set", 32'(timeout_o), 32'd1);
      step(2'b01, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("to_next_start", 32'(tx_start_o), 32'd1);
      chk("to_next_data", 32'(tx_data_o), 32'hBB);
      step(2'b01, 1'b0, 8'h00, 1'b1, 1'b1);
      chk("to_clear", 32'(timeout_o), 32'd0);

      // Asynchronous reset in the middle of WAIT_DONE with bytes queued.
      for (int i = 0; i < 6; i++) step(2'b01, 1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0);
      chk("rst_pre_level", 32'(fifo_level_o), 32'd5);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async", 32'(pack(tx_start_o, tx_data_o, fifo_level_o, overflow_o, timeout_o)), 32'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      nst = 0;
      for (int c = 0; c < 20; c++) begin
         step(2'b01, 1'b0, 8'h00, 1'b0, 1'b0);
         nst += int'(tx_start_o);
      end
      chk("rst_quiet", 32'(nst), 32'd0);
      step(2'b01, 1'b1, 8'hE7, 1'b0, 1'b0);
      step(2'b01, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("rst_new_start", 32'(pack(tx_start_o, tx_data_o, fifo_level_o, 1'b0, 1'b0)),
                           32'(pack(1'b1, 8'hE7, 5'd0, 1'b0, 1'b0)));
      step(2'b01, 1'b0, 8'h00, 1'b1, 1'b0);

      // Random traffic against the model: busy transmitter first, then a stalling one.
      rm = 2'b01;
      for (int c = 0; c < 3000; c++) begin
         dp = (c < 1500) ? 5 : 70;
         if ($urandom_range(0, 199) == 0) rm = 2'($urandom);
         step(rm, $urandom_range(0, 3) == 0, 8'($urandom),
              $urandom_range(0, dp) == 0, $urandom_range(0, 150) == 0);
      end

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
